// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared types for the data memory access path: access size encoding,
// arbiter FSM states, port count, and the alignment/legality rule applied
// to every request before it reaches the memory.
// ---------------------------------------------------------------------------
package data_mem_pkg;

  localparam int NPORTS = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // A request is legal when its size is defined and the address is
  // naturally aligned for that size.
  function automatic logic is_legal(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
// Combinational size/sign extension of load data coming back from memory.
// The memory already zero-pads narrow reads, so only the signed byte and
// signed half cases need to modify the value.
//   data      in   32  raw (zero-padded) read data
//   size      in   2   access size (size_e)
//   is_signed in   1   1 = lb/lh style sign extension
//   ext       out  32  extended result
// ---------------------------------------------------------------------------
module mem_load_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] data,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    if (is_signed) begin
      case (size)
        SZ_BYTE: ext = {{24{data[7]}}, data[7:0]};
        SZ_HALF: ext = {{16{data[15]}}, data[15:0]};
        default: ext = data;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Round-robin arbiter and access sequencer sharing one byte-addressed data
// memory port between the load/store unit (port 0) and the debug/loader
// port (port 1). Each grant produces exactly one cycle of memory strobes
// followed by a one-cycle ack with error flag and extended read data.
//   clk, rst        clock / asynchronous active-high reset
//   req_i..wdata_i  per-port request fields (held until ack)
//   ack_o, err_o, rdata_o   per-port completion, shared error/data
//   mem_*           memory-side address, data and strobes
//   mem_data_out    combinational read data from memory
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORTS-1:0]             req_i,
  input  logic [NPORTS-1:0]             we_i,
  input  logic [NPORTS-1:0][1:0]        size_i,
  input  logic [NPORTS-1:0]             signed_i,
  input  logic [NPORTS-1:0][DEPTH-1:0]  addr_i,
  input  logic [NPORTS-1:0][WIDTH-1:0]  wdata_i,
  output logic [NPORTS-1:0]             ack_o,
  output logic                          err_o,
  output logic [WIDTH-1:0]              rdata_o,
  output logic [DEPTH-1:0]              mem_addr,
  output logic [WIDTH-1:0]              mem_data_in,
  output logic                          mem_wr,
  output logic                          mem_rd,
  output logic                          mem_one_byte,
  output logic                          mem_two_bytes,
  output logic                          mem_four_bytes,
  input  logic [WIDTH-1:0]              mem_data_out
);

  state_e      state;
  logic        last;
  logic        port;
  logic        lat_we;
  logic        lat_signed;
  logic        lat_legal;
  size_e       lat_size;

  logic        any_req;
  logic        winner;
  size_e       win_size;
  logic        win_legal;
  logic [31:0] ext_data;

  // On a tie the port that was not served last wins; otherwise the single
  // requester wins.
  always_comb begin
    any_req   = |req_i;
    winner    = (req_i == 2'b11) ? ~last : req_i[1];
    win_size  = size_e'(size_i[winner]);
    win_legal = is_legal(win_size, addr_i[winner][1:0]);
  end

  mem_load_ext u_load_ext (
    .data      (mem_data_out),
    .size      (lat_size),
    .is_signed (lat_signed),
    .ext       (ext_data)
  );

  // Strobes are registered at grant and cleared one cycle later, so they
  // are high for exactly the ACCESS cycle and an asynchronous reset pulls
  // them low before the falling edge on which a write would commit.
  // RESP always goes back to IDLE: the served port still holds req on that
  // edge and must not be granted a second time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      port           <= 1'b0;
      lat_we         <= 1'b0;
      lat_signed     <= 1'b0;
      lat_legal      <= 1'b0;
      lat_size       <= SZ_BYTE;
      ack_o          <= '0;
      err_o          <= 1'b0;
      rdata_o        <= '0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_wr         <= 1'b0;
      mem_rd         <= 1'b0;
      mem_one_byte   <= 1'b0;
      mem_two_bytes  <= 1'b0;
      mem_four_bytes <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_o   <= '0;
          err_o   <= 1'b0;
          rdata_o <= '0;
          if (any_req) begin
            port           <= winner;
            last           <= winner;
            lat_we         <= we_i[winner];
            lat_signed     <= signed_i[winner];
            lat_size       <= win_size;
            lat_legal      <= win_legal;
            mem_addr       <= addr_i[winner];
            mem_data_in    <= wdata_i[winner];
            mem_wr         <= win_legal & we_i[winner];
            mem_rd         <= win_legal & ~we_i[winner];
            mem_one_byte   <= win_legal & (win_size == SZ_BYTE);
            mem_two_bytes  <= win_legal & (win_size == SZ_HALF);
            mem_four_bytes <= win_legal & (win_size == SZ_WORD);
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wr         <= 1'b0;
          mem_rd         <= 1'b0;
          mem_one_byte   <= 1'b0;
          mem_two_bytes  <= 1'b0;
          mem_four_bytes <= 1'b0;
          ack_o          <= 2'b01 << port;
          err_o          <= ~lat_legal;
          rdata_o        <= (lat_legal & ~lat_we) ? ext_data : '0;
          state          <= RESP;
        end
        RESP: begin
          ack_o   <= '0;
          err_o   <= 1'b0;
          rdata_o <= '0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Bench for data_mem_arbiter. A byte array emulates the memory behind the
// arbiter (zero-padded combinational reads, writes on the falling edge),
// and a separate associative byte map is the reference model that predicts
// load results from the stores the bench itself has issued.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int DEPTH = 20;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [1:0]                  req_i;
  logic [1:0]                  we_i;
  logic [1:0][1:0]             size_i;
  logic [1:0]                  signed_i;
  logic [1:0][DEPTH-1:0]       addr_i;
  logic [1:0][31:0]            wdata_i;
  logic [1:0]                  ack_o;
  logic                        err_o;
  logic [31:0]                 rdata_o;
  logic [DEPTH-1:0]            mem_addr;
  logic [31:0]                 mem_data_in;
  logic                        mem_wr, mem_rd;
  logic                        mem_one_byte, mem_two_bytes, mem_four_bytes;
  logic [31:0]                 mem_data_out;

  logic [7:0] emem [0:(1<<DEPTH)-1];
  logic [7:0] ref_mem [int];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .we_i           (we_i),
    .size_i         (size_i),
    .signed_i       (signed_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .ack_o          (ack_o),
    .err_o          (err_o),
    .rdata_o        (rdata_o),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_one_byte   (mem_one_byte),
    .mem_two_bytes  (mem_two_bytes),
    .mem_four_bytes (mem_four_bytes),
    .mem_data_out   (mem_data_out)
  );

  // Emulated memory: little-endian, zero-padded reads selected by the size strobes.
  always_comb begin
    mem_data_out = 32'h0;
    if (mem_one_byte)
      mem_data_out = {24'h0, emem[mem_addr]};
    else if (mem_two_bytes)
      mem_data_out = {16'h0, emem[mem_addr + 20'd1], emem[mem_addr]};
    else if (mem_four_bytes)
      mem_data_out = {emem[mem_addr + 20'd3], emem[mem_addr + 20'd2],
                      emem[mem_addr + 20'd1], emem[mem_addr]};
  end

  always @(negedge clk) begin
    if (mem_wr) begin
      emem[mem_addr] <= mem_data_in[7:0];
      if (mem_two_bytes || mem_four_bytes)
        emem[mem_addr + 20'd1] <= mem_data_in[15:8];
      if (mem_four_bytes) begin
        emem[mem_addr + 20'd2] <= mem_data_in[23:16];
        emem[mem_addr + 20'd3] <= mem_data_in[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_byte(input int a);
    int k;
    k = a & ((1 << DEPTH) - 1);
    return ref_mem.exists(k) ? {24'h0, ref_mem[k]} : 32'h0;
  endfunction

  // Reference load value from the byte map using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = ref_byte(a);
        if (sg && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = ref_byte(a) + 32'd256 * ref_byte(a + 1);
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = ref_byte(a) + 32'd256 * ref_byte(a + 1)
                 + 32'd65536 * ref_byte(a + 2) + 32'd16777216 * ref_byte(a + 3);
    endcase
    return v;
  endfunction

  function automatic logic ref_legal(input logic [1:0] sz, input logic [DEPTH-1:0] a);
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1) return (a % 2) == 0;
    if (sz == 2'd2) return (a % 4) == 0;
    return 1'b1;
  endfunction

  // One complete transaction on a single port with all timing checks.
  task automatic do_access(input int p, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [DEPTH-1:0] a, input logic [31:0] wd);
    logic        legal;
    logic [4:0]  exp_strb;
    logic [4:0]  got_strb;
    logic [31:0] exp_rd;
    legal    = ref_legal(sz, a);
    exp_strb = legal ? {we, ~we, sz == 2'd0, sz == 2'd1, sz == 2'd2} : 5'b0;
    exp_rd   = (legal && !we) ? ref_load(sz, sg, int'(a)) : 32'h0;
    we_i[p] = we; size_i[p] = sz; signed_i[p] = sg; addr_i[p] = a; wdata_i[p] = wd;
    req_i[p] = 1'b1;
    @(negedge clk);
    got_strb = {mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes};
    total++;
    if (got_strb !== exp_strb) begin
      bad++;
      $display("[TB] FAIL strobes p=%0d addr=%h got=%b want=%b", p, a, got_strb, exp_strb);
    end
    total++;
    if (mem_addr !== a) begin
      bad++;
      $display("[TB] FAIL mem_addr got=%h want=%h", mem_addr, a);
    end
    if (legal && we) begin
      total++;
      if (mem_data_in !== wd) begin
        bad++;
        $display("[TB] FAIL mem_data_in got=%h want=%h", mem_data_in, wd);
      end
    end
    // Fields are already latched; scramble them to prove it.
    size_i[p] = 2'($urandom); signed_i[p] = 1'($urandom);
    addr_i[p] = DEPTH'($urandom); wdata_i[p] = $urandom; we_i[p] = 1'($urandom);
    @(negedge clk);
    total++;
    if (ack_o !== (2'b01 << p) || err_o !== !legal || rdata_o !== exp_rd) begin
      bad++;
      $display("[TB] FAIL response p=%0d ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
               p, ack_o, err_o, rdata_o, 2'b01 << p, !legal, exp_rd);
    end
    if (legal && we) begin
      ref_mem[int'(a)] = wd[7:0];
      if (sz != 2'd0) ref_mem[int'(a) + 1] = wd[15:8];
      if (sz == 2'd2) begin
        ref_mem[int'(a) + 2] = wd[23:16];
        ref_mem[int'(a) + 3] = wd[31:24];
      end
    end
    @(negedge clk);
    total++;
    if (ack_o !== 2'b00) begin
      bad++;
      $display("[TB] FAIL ack_pulse got=%b want=00", ack_o);
    end
    req_i[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = '0; we_i = '0; size_i = '0; signed_i = '0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({ack_o, err_o, rdata_o} !== 35'h0) begin
      bad++;
      $display("[TB] FAIL reset_resp ack=%b err=%b rdata=%h want 0", ack_o, err_o, rdata_o);
    end
    total++;
    if ({mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_strobes got=%b want=00000",
               {mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes});
    end
    total++;
    if (mem_addr !== '0 || mem_data_in !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mem_bus addr=%h data=%h want 0", mem_addr, mem_data_in);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load_word();
    do_access(0, 1'b1, 2'd2, 1'b0, 20'h00010, 32'hDEADBEEF);
    do_access(0, 1'b0, 2'd2, 1'b0, 20'h00010, 32'h0);
  endtask

  task automatic test_byte_sign();
    do_access(0, 1'b1, 2'd0, 1'b0, 20'h00003, 32'h00000080);
    do_access(0, 1'b0, 2'd0, 1'b1, 20'h00003, 32'h0);
    do_access(1, 1'b0, 2'd0, 1'b0, 20'h00003, 32'h0);
  endtask

  task automatic test_illegal();
    do_access(0, 1'b0, 2'd1, 1'b1, 20'h00001, 32'h0);
    do_access(1, 1'b0, 2'd2, 1'b0, 20'h00002, 32'h0);
    do_access(0, 1'b1, 2'd3, 1'b0, 20'h00040, 32'h55AA55AA);
  endtask

  // Both ports request from reset; grants must alternate 0,1,0,1 every 3 cycles.
  task automatic test_round_robin();
    logic [1:0]       exp_ack;
    logic [DEPTH-1:0] exp_addr;
    rst = 1'b1;
    we_i = 2'b00; size_i[0] = 2'd2; size_i[1] = 2'd2; signed_i = 2'b00;
    addr_i[0] = 20'h00100; addr_i[1] = 20'h00204; wdata_i = '0;
    req_i = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_ack = (i % 3 == 2) ? (2'b01 << ((i / 3) % 2)) : 2'b00;
      total++;
      if (ack_o !== exp_ack) begin
        bad++;
        $display("[TB] FAIL rr_ack cycle=%0d got=%b want=%b", i, ack_o, exp_ack);
      end
      if (i % 3 == 1) begin
        exp_addr = (((i - 1) / 3) % 2 == 0) ? 20'h00100 : 20'h00204;
        total++;
        if (mem_addr !== exp_addr || mem_rd !== 1'b1) begin
          bad++;
          $display("[TB] FAIL rr_grant cycle=%0d addr=%h rd=%b want addr=%h rd=1",
                   i, mem_addr, mem_rd, exp_addr);
        end
      end
    end
    req_i = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    we_i[0] = 1'b1; size_i[0] = 2'd2; signed_i[0] = 1'b0;
    addr_i[0] = 20'h00020; wdata_i[0] = 32'h12345678;
    req_i[0] = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (mem_wr !== 1'b1 || mem_four_bytes !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_pre wr=%b four=%b want 1 1", mem_wr, mem_four_bytes);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes, ack_o} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL midrst_drop strobes=%b ack=%b want 0",
               {mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes}, ack_o);
    end
    @(negedge clk);
    req_i = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (ack_o !== 2'b00) begin
        bad++;
        $display("[TB] FAIL midrst_noack cycle=%0d got=%b want=00", i, ack_o);
      end
    end
    do_access(0, 1'b0, 2'd2, 1'b0, 20'h00020, 32'h0);
  endtask

  task automatic test_random();
    int               p, r;
    logic [1:0]       sz;
    logic [DEPTH-1:0] a;
    for (int n = 0; n < 60; n++) begin
      p = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      a = 20'h00100 + DEPTH'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_access(p, 1'($urandom), sz, 1'($urandom), a, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << DEPTH); i++) emem[i] = 8'h00;
    test_reset();
    test_store_load_word();
    test_byte_sign();
    test_illegal();
    test_round_robin();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory. It shares the single memory port between the core load/store unit (port 0) and the debug/loader port (port 1) using round-robin arbitration. It converts each granted request into one cycle of memory strobes with exactly one size strobe active, and returns sign- or zero-extended read data with an ack/err handshake.

## Interface

Parameters:
- WIDTH, 32: data width; only 32 is supported.
- DEPTH, 20: address width in bits; the memory holds 2**DEPTH bytes.

Ports:
- clk  in  1  clock; memory writes commit on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- req_i[1:0]  in  2  request per port; held high until that port's ack.
- we_i[1:0]  in  2  per-port write enable (1 = store, 0 = load).
- size_i[1:0][1:0]  in  2x2  per-port access size: 00 byte, 01 half, 10 word, 11 illegal.
- signed_i[1:0]  in  2  per-port load sign-extension select (lb/lh vs lbu/lhu).
- addr_i[1:0]  in  2xDEPTH  per-port byte address.
- wdata_i[1:0]  in  2xWIDTH  per-port store data, low-aligned.
- ack_o[1:0]  out  2  one-cycle completion pulse per port.
- err_o  out  1  valid with ack; 1 = request rejected.
- rdata_o  out  WIDTH  extended load data; valid with ack.
- mem_addr  out  DEPTH  memory byte address.
- mem_data_in  out  WIDTH  memory write data.
- mem_wr, mem_rd  out  1  memory strobes.
- mem_one_byte, mem_two_bytes, mem_four_bytes  out  1  memory size strobes; at most one is high.
- mem_data_out  in  WIDTH  combinational memory read data, zero-padded.

## Operation

- FSM states and transitions:
  - IDLE: an edge where any req_i is high selects a winner, latches its we/size/signed/addr/wdata into the request registers, and moves to ACCESS.
  - ACCESS: strobes driven from the latched registers for exactly one cycle; next state is RESP.
  - RESP: ack of the served port high; next state is IDLE.
- Arbitration is round-robin through a 1-bit pointer `last`.
  - Both ports requesting: the port ≠ last wins.
  - One port requesting: that port wins.
  - `last` updates to the winner on grant.
- RESP always returns to IDLE, never directly to a new grant. The served port's req is still high on that edge, and re-arbitrating would serve it twice.
- Legality check, made at latch time:
  - size 11 is illegal.
  - Half access with addr[0]=1 is illegal.
  - Word access with addr[1:0]≠00 is illegal.
- An illegal request still passes through ACCESS, but with all mem_* strobes low. In RESP it gives err_o=1 and rdata_o=0.
- Store: mem_wr=1 and the size strobe are high for the ACCESS cycle; the write commits on that cycle's falling edge. On ack, rdata_o=0 and err_o=0.
- Load: mem_rd=1 and the size strobe are high. mem_data_out is registered at the ACCESS→RESP edge and then extended:
  - byte with signed_i: bit 7 replicated into [31:8].
  - half with signed_i: bit 15 replicated into [31:16].
  - unsigned or word: data passed through as received.
- Outside ACCESS, all mem_* strobes are 0 and mem_addr/mem_data_in hold their latched values.

## Timing

- Request latched at edge k. ACCESS runs k..k+1, ack is high k+1..k+2, back in IDLE at k+2.
- The earliest re-grant of either port is edge k+3, so throughput is one access per 3 cycles.
- The requester may drop or change req/fields at edge k+2. Fields may change freely once latched at edge k.
- Reset values, forced asynchronously and immediately:
  - state IDLE, last=1 (port 0 wins the first tie).
  - ack_o=00, err_o=0, rdata_o=0.
  - all mem_* strobes 0, mem_addr=0, mem_data_in=0.
- Reset asserted during ACCESS drops the strobes before the falling edge, so no write commits. Reset during RESP suppresses the ack; the requester re-requests after reset.
- req deasserted before ack is a protocol violation; its behaviour is unspecified.

## Structure

- Package data_mem_pkg holds:
  - size_e: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - state_e: IDLE, ACCESS, RESP.
  - localparam NPORTS = 2.
- Sub-module mem_load_ext: combinational size/sign extension of read data (inputs data, size, signed). It is reusable by the core writeback path.
- Arbiter, request registers and legality check stay in the top module.

## Test plan

- Port 0 store word 0xDEADBEEF at 0x00010, then load word at 0x00010 → mem_four_bytes with mem_wr in the first ACCESS; ack_o[0] at k+1 both times; second rdata_o=0xDEADBEEF, err_o=0.
- Store byte 0x80 at 0x00003, then lb and lbu at 0x00003 → lb gives 0xFFFFFF80 and lbu gives 0x00000080; only mem_one_byte is high in each access.
- req_i=11 held continuously from reset → grants alternate 0,1,0,1 at edges k, k+3, k+6, k+9; each ack is a single-cycle pulse.
- Half load at 0x00001, word load at 0x00002, and size 11 → no mem_* strobe ever high; err_o=1 with ack; rdata_o=0.
- rst asserted mid-ACCESS of a word store of 0x12345678 to 0x00020 → strobes drop immediately; no ack; a later load at 0x00020 returns the pre-store value.
